// File: rtl/spi_mem_arbiter.sv
// Round-robin arbiter with a bounded burst lock that shares one single-port
// buffer RAM between SPI load, conv write-back and SPI readout requesters.
module spi_mem_arbiter #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 16
) (
  input  logic                clk_spi,
  input  logic                reset,
  input  logic [2:0]          req,
  input  logic [2:0]          we,
  input  logic [3*ADDR_W-1:0] addr,
  input  logic [3*DATA_W-1:0] wdata,
  output logic [2:0]          gnt,
  output logic [2:0]          rvalid,
  output logic [DATA_W-1:0]   rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic [1:0]          owner,
  output logic                busy
);

  localparam int              CNT_W    = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

  logic             owner_vld_q, owner_vld_d;
  logic [1:0]       owner_q, owner_d;
  logic [1:0]       last_q, last_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [2:0]       rvalid_q;
  logic [2:0]       own_oh_s;
  logic [2:0]       cand_s;
  logic [2:0]       win_s;
  logic             pick_s;
  logic             excl_s;

  // Returns {found, index}; search begins at last+1 and wraps modulo 3.
  function automatic logic [2:0] rr_pick(input logic [2:0] cand, input logic [1:0] last);
    logic [2:0] res;
    res = 3'b000;
    case (last)
      2'd0: begin
        if (cand[1])      res = {1'b1, 2'd1};
        else if (cand[2]) res = {1'b1, 2'd2};
        else if (cand[0]) res = {1'b1, 2'd0};
        else              res = 3'b000;
      end
      2'd1: begin
        if (cand[2])      res = {1'b1, 2'd2};
        else if (cand[0]) res = {1'b1, 2'd0};
        else if (cand[1]) res = {1'b1, 2'd1};
        else              res = 3'b000;
      end
      default: begin
        if (cand[0])      res = {1'b1, 2'd0};
        else if (cand[1]) res = {1'b1, 2'd1};
        else if (cand[2]) res = {1'b1, 2'd2};
        else              res = 3'b000;
      end
    endcase
    return res;
  endfunction

  always_comb begin
    case (owner_q)
      2'd0:    own_oh_s = 3'b001;
      2'd1:    own_oh_s = 3'b010;
      2'd2:    own_oh_s = 3'b100;
      default: own_oh_s = 3'b000;
    endcase
    if (owner_vld_q && !reset) gnt = own_oh_s & req;
    else                       gnt = 3'b000;
  end

  always_comb begin
    mem_en    = |gnt;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (gnt)
      3'b001: begin
        mem_we = we[0]; mem_addr = addr[0 +: ADDR_W]; mem_wdata = wdata[0 +: DATA_W];
      end
      3'b010: begin
        mem_we = we[1]; mem_addr = addr[ADDR_W +: ADDR_W]; mem_wdata = wdata[DATA_W +: DATA_W];
      end
      3'b100: begin
        mem_we = we[2]; mem_addr = addr[2*ADDR_W +: ADDR_W]; mem_wdata = wdata[2*DATA_W +: DATA_W];
      end
      default: mem_we = 1'b0;
    endcase
  end

  // A burst-limit release only hands over when someone else is waiting.
  always_comb begin
    owner_vld_d = owner_vld_q;
    owner_d     = owner_q;
    last_d      = last_q;
    beat_cnt_d  = beat_cnt_q;
    pick_s      = 1'b0;
    excl_s      = 1'b0;
    cand_s      = 3'b000;
    win_s       = 3'b000;
    if (!owner_vld_q) begin
      pick_s = 1'b1;
    end else if ((req & own_oh_s) == 3'b000) begin
      pick_s = 1'b1;
      last_d = owner_q;
    end else if (beat_cnt_q == CNT_LAST) begin
      if ((req & ~own_oh_s) != 3'b000) begin
        pick_s = 1'b1;
        excl_s = 1'b1;
        last_d = owner_q;
      end else begin
        beat_cnt_d = '0;
      end
    end else begin
      beat_cnt_d = beat_cnt_q + CNT_W'(1);
    end
    if (pick_s) begin
      cand_s      = excl_s ? (req & ~own_oh_s) : req;
      win_s       = rr_pick(cand_s, last_d);
      owner_vld_d = win_s[2];
      owner_d     = win_s[2] ? win_s[1:0] : owner_q;
      beat_cnt_d  = '0;
    end else begin
      cand_s = 3'b000;
    end
  end

  always_ff @(posedge clk_spi) begin
    if (reset) begin
      owner_vld_q <= 1'b0;
      owner_q     <= 2'd0;
      last_q      <= 2'd2;
      beat_cnt_q  <= '0;
      rvalid_q    <= 3'b000;
    end else begin
      owner_vld_q <= owner_vld_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      beat_cnt_q  <= beat_cnt_d;
      rvalid_q    <= gnt & ~we;
    end
  end

  assign rvalid = rvalid_q & {3{~reset}};
  assign rdata  = mem_rdata;
  assign owner  = owner_q;
  assign busy   = owner_vld_q;

endmodule

// File: tb/tb_spi_mem_arbiter.sv
// Scoreboard bench: stimulus pushes expected RAM beats and read returns,
// a negedge monitor pops and compares whenever the arbiter drives them.
module tb_spi_mem_arbiter;

  logic        clk_spi = 1'b0;
  logic        reset;
  logic [2:0]  req;
  logic [2:0]  we;
  logic [47:0] addr;
  logic [23:0] wdata;

  logic [2:0]  gnt4, rvalid4, gnt16, rvalid16;
  logic [7:0]  rdata4, rdata16, mem_wdata4, mem_wdata16;
  logic        mem_en4, mem_we4, mem_en16, mem_we16, busy4, busy16;
  logic [15:0] mem_addr4, mem_addr16;
  logic [1:0]  owner4, owner16;
  logic [7:0]  ram [0:4095];
  logic [7:0]  ram_q;

  int n_checks = 0;
  int n_fail   = 0;
  logic [27:0] beat_q [$];
  logic [10:0] rd_q [$];

  always #5 clk_spi = ~clk_spi;

  spi_mem_arbiter #(.ADDR_W(16), .DATA_W(8), .MAX_BURST(4)) u4 (
    .clk_spi(clk_spi), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt4), .rvalid(rvalid4), .rdata(rdata4), .mem_en(mem_en4), .mem_we(mem_we4),
    .mem_addr(mem_addr4), .mem_wdata(mem_wdata4), .mem_rdata(ram_q),
    .owner(owner4), .busy(busy4));

  spi_mem_arbiter #(.ADDR_W(16), .DATA_W(8), .MAX_BURST(16)) u16 (
    .clk_spi(clk_spi), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt16), .rvalid(rvalid16), .rdata(rdata16), .mem_en(mem_en16), .mem_we(mem_we16),
    .mem_addr(mem_addr16), .mem_wdata(mem_wdata16), .mem_rdata(ram_q),
    .owner(owner16), .busy(busy16));

  always @(posedge clk_spi) begin
    if (mem_en4) begin
      if (mem_we4) ram[mem_addr4[11:0]] <= mem_wdata4;
      else         ram_q <= ram[mem_addr4[11:0]];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk_spi) begin
    if (mem_en4) begin
      if (beat_q.size() == 0) check("unexpected_beat", {4'h0, gnt4, mem_we4, mem_addr4, mem_wdata4}, 32'h0);
      else check("beat", {4'h0, gnt4, mem_we4, mem_addr4, mem_wdata4}, {4'h0, beat_q.pop_front()});
    end
    if (|rvalid4) begin
      if (rd_q.size() == 0) check("unexpected_rvalid", {21'h0, rvalid4, rdata4}, 32'h0);
      else check("rdata", {21'h0, rvalid4, rdata4}, {21'h0, rd_q.pop_front()});
    end
  end

  task automatic tick();
    @(posedge clk_spi);
    #1;
  endtask

  task automatic set_rq(input int i, input logic w, input logic [15:0] a, input logic [7:0] d);
    we[i]           = w;
    addr[i*16 +: 16] = a;
    wdata[i*8 +: 8]  = d;
  endtask

  task automatic exp_beat(input logic [2:0] g, input logic w, input logic [15:0] a, input logic [7:0] d);
    beat_q.push_back({g, w, a, d});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int o;
    reset = 1'b1; req = 3'b000; we = 3'b000; addr = 48'h0; wdata = 24'h0;
    repeat (3) tick();
    @(negedge clk_spi);
    check("rst_gnt", {29'h0, gnt4}, 32'h0);
    check("rst_mem_en", {31'h0, mem_en4}, 32'h0);
    check("rst_busy", {31'h0, busy4}, 32'h0);
    check("rst_owner", {30'h0, owner4}, 32'h0);
    check("rst_rvalid", {29'h0, rvalid4}, 32'h0);
    check("rst_last", {30'h0, u4.last_q}, 32'h2);

    // requester 0 writes four beats
    tick();
    reset = 1'b0;
    set_rq(0, 1'b1, 16'h0000, 8'hA0);
    req = 3'b001;
    tick();
    for (int k = 0; k < 4; k++) begin
      set_rq(0, 1'b1, 16'(k), 8'(8'hA0 + k));
      exp_beat(3'b001, 1'b1, 16'(k), 8'(8'hA0 + k));
      @(negedge clk_spi);
      check("wr_gnt0", {29'h0, gnt4}, 32'h1);
      tick();
    end
    req = 3'b000;
    tick();
    @(negedge clk_spi);
    check("idle_busy", {31'h0, busy4}, 32'h0);

    // requester 2 reads back address 2
    set_rq(2, 1'b0, 16'h0002, 8'h55);
    req = 3'b100;
    tick();
    exp_beat(3'b100, 1'b0, 16'h0002, 8'h55);
    rd_q.push_back({3'b100, 8'hA2});
    @(negedge clk_spi);
    check("rd_gnt2", {29'h0, gnt4}, 32'h4);
    check("rd_rvalid_early", {29'h0, rvalid4}, 32'h0);
    tick();
    req = 3'b000;
    @(negedge clk_spi);
    check("rd_rvalid", {29'h0, rvalid4}, 32'h4);
    check("rd_rdata", {24'h0, rdata4}, 32'hA2);
    tick();

    // all three contend with MAX_BURST=4: 0x4, 1x4, 2x4, 0x4 with no gaps
    we  = 3'b111;
    req = 3'b111;
    tick();
    for (int c = 0; c < 16; c++) begin
      o = (c / 4) % 3;
      set_rq(o, 1'b1, 16'(256 * (o + 1) + c), 8'(c));
      exp_beat(3'(1 << o), 1'b1, 16'(256 * (o + 1) + c), 8'(c));
      @(negedge clk_spi);
      check("rr_gnt", {29'h0, gnt4}, 32'(1 << o));
      tick();
    end
    req = 3'b000;
    @(negedge clk_spi);
    check("rr_drop_gnt", {29'h0, gnt4}, 32'h0);
    tick();

    // requester 1 alone for 40 beats: never released
    set_rq(1, 1'b1, 16'h0400, 8'h40);
    req = 3'b010;
    tick();
    for (int c = 0; c < 40; c++) begin
      set_rq(1, 1'b1, 16'(16'h0400 + c), 8'(8'h40 + c));
      exp_beat(3'b010, 1'b1, 16'(16'h0400 + c), 8'(8'h40 + c));
      @(negedge clk_spi);
      check("solo_gnt_mb4", {29'h0, gnt4}, 32'h2);
      check("solo_gnt_mb16", {29'h0, gnt16}, 32'h2);
      tick();
    end

    // requester 2 waits, requester 1 drops after two more beats
    set_rq(2, 1'b1, 16'h0300, 8'h99);
    req = 3'b110;
    for (int c = 0; c < 2; c++) begin
      set_rq(1, 1'b1, 16'(16'h0500 + c), 8'(c));
      exp_beat(3'b010, 1'b1, 16'(16'h0500 + c), 8'(c));
      @(negedge clk_spi);
      check("hand_gnt1", {29'h0, gnt4}, 32'h2);
      tick();
    end
    req = 3'b100;
    @(negedge clk_spi);
    check("hand_gap", {29'h0, gnt4}, 32'h0);
    tick();
    exp_beat(3'b100, 1'b1, 16'h0300, 8'h99);
    @(negedge clk_spi);
    check("hand_gnt2", {29'h0, gnt4}, 32'h4);
    check("hand_owner", {30'h0, owner4}, 32'h2);
    check("hand_last", {30'h0, u4.last_q}, 32'h1);
    tick();

    // requester 2 read burst interrupted by reset
    set_rq(2, 1'b0, 16'h0000, 8'h99);
    exp_beat(3'b100, 1'b0, 16'h0000, 8'h99);
    rd_q.push_back({3'b100, 8'hA0});
    @(negedge clk_spi);
    check("rb_gnt2a", {29'h0, gnt4}, 32'h4);
    tick();
    set_rq(2, 1'b0, 16'h0001, 8'h99);
    exp_beat(3'b100, 1'b0, 16'h0001, 8'h99);
    @(negedge clk_spi);
    check("rb_gnt2b", {29'h0, gnt4}, 32'h4);
    check("rb_rvalid_a", {29'h0, rvalid4}, 32'h4);
    tick();
    reset = 1'b1;
    set_rq(0, 1'b1, 16'h0030, 8'h77);
    req = 3'b101;
    @(negedge clk_spi);
    check("rst_mid_gnt", {29'h0, gnt4}, 32'h0);
    check("rst_mid_mem_en", {31'h0, mem_en4}, 32'h0);
    check("rst_mid_rvalid", {29'h0, rvalid4}, 32'h0);
    tick();
    reset = 1'b0;
    @(negedge clk_spi);
    check("post_rst_gnt", {29'h0, gnt4}, 32'h0);
    check("post_rst_mem_en", {31'h0, mem_en4}, 32'h0);
    check("post_rst_rvalid", {29'h0, rvalid4}, 32'h0);
    check("post_rst_busy", {31'h0, busy4}, 32'h0);
    tick();
    exp_beat(3'b001, 1'b1, 16'h0030, 8'h77);
    @(negedge clk_spi);
    check("post_rst_gnt0", {29'h0, gnt4}, 32'h1);
    tick();
    req = 3'b000;
    tick();
    tick();
    @(negedge clk_spi);
    check("beats_left", 32'(beat_q.size()), 32'h0);
    check("reads_left", 32'(rd_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_mem_arbiter.md
# spi_mem_arbiter

Three-way arbiter that shares one single-port, 1-cycle-read-latency buffer RAM (weights/bias/input staging, `ram4k`-class) between the SPI load path, the convolution write-back path and the SPI readout path. It sits in the `clk_spi` domain between the command controller, the conv engine result port and the SPI sink streamer. It grants the port round-robin with a bounded burst lock, muxes address/data/write-enable onto the RAM and routes read-valid back to the issuing requester.

## Interface
- `ADDR_W`, 16, RAM address width.
- `DATA_W`, 8, RAM data width.
- `MAX_BURST`, 16, max consecutive beats one requester keeps while others wait (≥1, ≤256).
- `clk_spi`  in  1  clock; reset is synchronous, active-high, named `reset`.
- `reset`  in  1  synchronous active-high reset.
- `req`  in  3  per-requester request (0 = SPI load, 1 = conv write-back, 2 = readout).
- `we`  in  3  per-requester write enable (1 = write, 0 = read), valid with `req`.
- `addr`  in  3*ADDR_W  packed addresses, requester i at `[i*ADDR_W +: ADDR_W]`.
- `wdata`  in  3*DATA_W  packed write data, same packing.
- `gnt`  out  3  one-hot grant; a beat completes on each rising edge with `gnt[i]`=1.
- `rvalid`  out  3  read data valid for requester i.
- `rdata`  out  DATA_W  read data, broadcast to all requesters.
- `mem_en`, `mem_we`  out  1  RAM enable, write enable.
- `mem_addr`  out  ADDR_W; `mem_wdata`  out  DATA_W.
- `mem_rdata`  in  DATA_W  RAM read data, 1 cycle after a read beat.
- `owner`  out  2; `busy`  out  1  debug: current owner index, owner valid.

## Operation
- State: `owner_vld`, `owner[1:0]`, `last[1:0]`, `beat_cnt` (width clog2(MAX_BURST)).
- `gnt[i] = owner_vld & (owner==i) & req[i] & ~reset` (combinational from registered state).
- RAM mux (combinational): `mem_en = |gnt`; `mem_we = mem_en & we[owner]`; `mem_addr/mem_wdata` = owner's fields when `mem_en`, else 0.
- Per edge, new-owner pick when `!owner_vld` or release: search `req` round-robin starting at `last+1` mod 3, wrapping; excluded requester = releasing owner on burst release. Winner -> `owner`, `owner_vld=1`, `beat_cnt=0`. No candidate -> `owner_vld=0`.
- Release conditions (owner_vld=1):
  - `!req[owner]`: release, `last<=owner`.
  - beat completed with `beat_cnt==MAX_BURST-1` and another req pending: release, `last<=owner`, owner ineligible for this pick.
  - same with no other req pending: keep owner, `beat_cnt<=0`.
- Otherwise a completed beat increments `beat_cnt`.
- Requester must hold `req`, `we`, `addr`, `wdata` stable until `gnt`; may change them each beat while granted (streaming).
- Read return: `rvalid[i] <= gnt[i] & ~we[i]`; `rdata = mem_rdata` (pass-through).
- Write and read never occur same cycle (single port, one-hot grant).

## Timing
- Reset values: `owner_vld=0`, `owner=0`, `last=2` (so requester 0 wins first), `beat_cnt=0`, `rvalid=0`; all `gnt`, `mem_*` = 0 while `reset`=1.
- Arbitration latency: `req` rising with idle port -> `gnt` on next cycle (1 cycle).
- Handover: owner drops `req` at edge N -> new owner's `gnt` high in cycle after edge N; zero-beat gap beyond that one cycle. Burst-limit handover: no gap.
- Read latency: `rvalid[i]`/`rdata` valid exactly one cycle after the read beat; back-to-back reads give back-to-back `rvalid`.
- Reset mid-burst: grant drops in the reset cycle itself; in-flight `rvalid` for a beat completed on the reset edge is suppressed (cleared).
- Throughput: one beat/cycle under continuous requests, fairness bounded by 2*MAX_BURST cycles wait + 1.

## Test plan
- Single requester 0 writes addr 0x0000..0x0003 data 0xA0..0xA3 -> `gnt[0]` from cycle 1, four `mem_we` beats with those addr/data, then `busy`=0 after `req` drop.
- Requester 2 reads addr 0x0002 after the above -> `rvalid[2]`=1 one cycle after the beat, `rdata`=0xA2, `rvalid[0..1]`=0.
- All three `req` held high, MAX_BURST=4 -> grant sequence 0×4, 1×4, 2×4, 0×4..., no idle cycles between bursts.
- Only requester 1 held for 40 beats, MAX_BURST=16 -> continuous grant, no release, `beat_cnt` wraps 15->0.
- Requester 1 drops `req` after 2 beats while 2 waits -> `gnt[2]` asserted in the cycle after the drop edge; `last`=1.
- `reset` pulsed during a requester-2 read burst -> `gnt`, `mem_en`, `rvalid` 0 in reset cycle and the next; after release requester 0 wins first if pending.
